muldiv_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide operations issued to the execute stage alongside the single-cycle ALU. It accepts one operation at a time over a valid/ready handshake, runs a radix-2 shift-add (multiply) or restoring shift-subtract (divide) loop for 32 iterations, applies sign correction, and holds the 64-bit result on `oHi`/`oLo` until the consumer accepts it. Divide-by-zero, signed overflow and illegal `iFunc7` take a 2-cycle fast path.

---
 rtl/muldiv_pkg.sv | 45 ++++
 rtl/muldiv_step.sv | 54 +++++
 rtl/muldiv_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared types, constants and helpers for the RV32M multiply/divide sequencer.
//   state_e             : sequencer states
//   OP_*                : iFunc3 operation encodings
//   MULDIV_FUNC7        : iFunc7 value that marks an M-extension instruction
//   DIV_ZERO_Q          : quotient returned for a zero divisor
//   INT_MIN             : most negative 32-bit value (signed overflow operand)
//   is_div / a_signed / b_signed : per-op decode helpers keyed on func3
package muldiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [6:0]  MULDIV_FUNC7 = 7'b0000001;
  localparam logic [31:0] DIV_ZERO_Q   = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN      = 32'h8000_0000;

  // All divide/remainder encodings have func3[2] set.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] f3);
    return (f3 == OP_MULH) || (f3 == OP_MULHSU) || (f3 == OP_DIV) || (f3 == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == OP_MULH) || (f3 == OP_DIV) || (f3 == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// One combinational iteration of the unsigned multiply/divide loop.
//   iIsDiv : 1 = restoring divide step, 0 = shift-add multiply step
//   iAcc   : 64-bit accumulator ({hi, lo})
//   iOpA   : multiplicand magnitude (mul) / remaining dividend bits (div)
//   iOpB   : remaining multiplier bits (mul) / divisor magnitude (div)
//   oAcc, oOpA, oOpB : register values after this iteration
// Multiply: hi half accumulates the multiplicand when the multiplier LSB
// is set, then the whole accumulator and the multiplier shift right.
// Divide: hi half is the partial remainder, lo half collects quotient bits.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              iIsDiv,
  input  logic [2*XLEN-1:0] iAcc,
  input  logic [XLEN-1:0]   iOpA,
  input  logic [XLEN-1:0]   iOpB,
  output logic [2*XLEN-1:0] oAcc,
  output logic [XLEN-1:0]   oOpA,
  output logic [XLEN-1:0]   oOpB
);

  logic [XLEN-1:0] mulAddend;
  logic [XLEN:0]   mulSum;
  logic [XLEN:0]   remShift;
  logic [XLEN:0]   remDiff;
  logic            remFits;
  logic [XLEN-1:0] remNext;

  assign mulAddend = iOpB[0] ? iOpA : {XLEN{1'b0}};
  // Carry out lands in the top bit so the shift keeps the full product.
  assign mulSum    = {1'b0, iAcc[2*XLEN-1:XLEN]} + {1'b0, mulAddend};

  // The remainder is always below the divisor, so the shifted value is
  // below twice the divisor and a 33-bit difference has a valid sign bit.
  assign remShift = {iAcc[2*XLEN-1:XLEN], iOpA[XLEN-1]};
  assign remDiff  = remShift - {1'b0, iOpB};
  assign remFits  = ~remDiff[XLEN];
  assign remNext  = remFits ? remDiff[XLEN-1:0] : remShift[XLEN-1:0];

  always_comb begin
    oAcc = iAcc;
    oOpA = iOpA;
    oOpB = iOpB;
    if (iIsDiv) begin
      oAcc = {remNext, iAcc[XLEN-2:0], remFits};
      oOpA = {iOpA[XLEN-2:0], 1'b0};
    end else begin
      oAcc = {mulSum, iAcc[XLEN-1:1]};
      oOpB = {1'b0, iOpB[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Multi-cycle RV32M multiply/divide sequencer with valid/ready on both sides.
//   iClk, iRst       : clock, synchronous active-high reset
//   iValid / oReady  : request handshake (oReady high only in IDLE)
//   iA, iB           : operands rs1/rs2, captured on the handshake
//   iFunc3, iFunc7   : operation select and M-extension marker
//   oValid / iReady  : result handshake (oValid high only in DONE)
//   oHi, oLo         : product bits [63:32]/[31:0], or remainder/quotient
//   oIllegal         : request carried a non-M iFunc7
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iValid,
  output logic            oReady,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic [2:0]      iFunc3,
  input  logic [6:0]      iFunc7,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oHi,
  output logic [XLEN-1:0] oLo,
  output logic            oIllegal
);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2:0]        func3_q, func3_d;
  logic              illReq_q, illReq_d;
  logic              signA_q, signA_d;
  logic              signB_q, signB_d;
  logic              fast_q, fast_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              illegal_q, illegal_d;

  logic              opIsDiv;
  logic              prepSignA, prepSignB;
  logic [XLEN-1:0]   magA, magB;
  logic              divByZero, divOverflow;
  logic [2*XLEN-1:0] prodFixed;
  logic [XLEN-1:0]   quotFixed, remFixed;
  logic [2*XLEN-1:0] stepAcc;
  logic [XLEN-1:0]   stepA, stepB;

  assign opIsDiv   = is_div(func3_q);
  assign prepSignA = a_signed(func3_q) & a_q[XLEN-1];
  assign prepSignB = b_signed(func3_q) & b_q[XLEN-1];
  assign magA      = prepSignA ? -a_q : a_q;
  assign magB      = prepSignB ? -b_q : b_q;

  assign divByZero   = opIsDiv && (b_q == '0);
  assign divOverflow = opIsDiv && b_signed(func3_q) && (a_q == INT_MIN) && (b_q == '1);

  // Remainder follows the dividend's sign; quotient and product follow
  // the XOR of both operand signs.
  assign prodFixed = (signA_q ^ signB_q) ? -acc_q : acc_q;
  assign quotFixed = (signA_q ^ signB_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign remFixed  = signA_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  muldiv_step #(.XLEN(XLEN)) uStep (
    .iIsDiv (opIsDiv),
    .iAcc   (acc_q),
    .iOpA   (a_q),
    .iOpB   (b_q),
    .oAcc   (stepAcc),
    .oOpA   (stepA),
    .oOpB   (stepB)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    func3_d   = func3_q;
    illReq_d  = illReq_q;
    signA_d   = signA_q;
    signB_d   = signB_q;
    fast_d    = fast_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    illegal_d = illegal_q;

    case (state_q)
      S_IDLE: begin
        if (iValid) begin
          a_d      = iA;
          b_d      = iB;
          func3_d  = iFunc3;
          illReq_d = (iFunc7 != MULDIV_FUNC7);
          state_d  = S_PREP;
        end
      end

      S_PREP: begin
        signA_d = prepSignA;
        signB_d = prepSignB;
        a_d     = magA;
        b_d     = magB;
        acc_d   = '0;
        cnt_d   = 5'd31;
        fast_d  = 1'b0;
        state_d = S_RUN;
        // Fast-path results are parked in the accumulator and published by
        // FIX, so every path writes the output registers in one place.
        if (illReq_q) begin
          fast_d  = 1'b1;
          state_d = S_FIX;
        end else if (divByZero) begin
          fast_d  = 1'b1;
          acc_d   = {a_q, DIV_ZERO_Q};
          state_d = S_FIX;
        end else if (divOverflow) begin
          fast_d  = 1'b1;
          acc_d   = {{XLEN{1'b0}}, INT_MIN};
          state_d = S_FIX;
        end
      end

      S_RUN: begin
        acc_d = stepAcc;
        a_d   = stepA;
        b_d   = stepB;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          cnt_d   = 5'd0;
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (fast_q) begin
          hi_d = acc_q[2*XLEN-1:XLEN];
          lo_d = acc_q[XLEN-1:0];
        end else if (opIsDiv) begin
          hi_d = remFixed;
          lo_d = quotFixed;
        end else begin
          hi_d = prodFixed[2*XLEN-1:XLEN];
          lo_d = prodFixed[XLEN-1:0];
        end
        illegal_d = illReq_q;
        state_d   = S_DONE;
      end

      S_DONE: begin
        if (iReady) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      func3_q   <= '0;
      illReq_q  <= 1'b0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      fast_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      func3_q   <= func3_d;
      illReq_q  <= illReq_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      fast_q    <= fast_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      illegal_q <= illegal_d;
    end
  end

  assign oReady   = (state_q == S_IDLE);
  assign oValid   = (state_q == S_DONE);
  assign oHi      = hi_q;
  assign oLo      = lo_q;
  assign oIllegal = illegal_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
// Directed-vector bench for muldiv_ctrl: hand-computed results, latency,
// output hold behaviour, mid-run reset and back-to-back throughput.
module tb_muldiv_ctrl;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValid;
  logic        oReady;
  logic [31:0] iA;
  logic [31:0] iB;
  logic [2:0]  iFunc3;
  logic [6:0]  iFunc7;
  logic        oValid;
  logic        iReady;
  logic [31:0] oHi;
  logic [31:0] oLo;
  logic        oIllegal;

  int total = 0;
  int bad   = 0;

  muldiv_ctrl #(.XLEN(32)) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iValid   (iValid),
    .oReady   (oReady),
    .iA       (iA),
    .iB       (iB),
    .iFunc3   (iFunc3),
    .iFunc7   (iFunc7),
    .oValid   (oValid),
    .iReady   (iReady),
    .oHi      (oHi),
    .oLo      (oLo),
    .oIllegal (oIllegal)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 iClk = ~iClk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request, scrambles the inputs after the accept edge, waits
  // for the result with a bounded loop, then checks latency, data, hold
  // while iReady is low and the release after the result handshake.
  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] expRes, input logic expIll, input int expLat);
    int lat;
    checkOutput({tag, "_ready"}, 64'(oReady), 64'd1);
    iA     = a;
    iB     = b;
    iFunc3 = f3;
    iFunc7 = f7;
    iValid = 1'b1;
    iReady = 1'b0;
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    iA     = $urandom;
    iB     = $urandom;
    iFunc3 = 3'($urandom);
    iFunc7 = 7'($urandom);
    lat = 0;
    while (!oValid && lat < 200) begin
      @(posedge iClk);
      #1;
      lat++;
    end
    checkOutput({tag, "_lat"}, 64'(lat), 64'(expLat));
    checkOutput({tag, "_res"}, {oHi, oLo}, expRes);
    checkOutput({tag, "_ill"}, 64'(oIllegal), 64'(expIll));
    repeat (2) @(posedge iClk);
    #1;
    checkOutput({tag, "_holdValid"}, 64'(oValid), 64'd1);
    checkOutput({tag, "_holdRes"}, {oHi, oLo}, expRes);
    iReady = 1'b1;
    @(posedge iClk);
    #1;
    iReady = 1'b0;
    checkOutput({tag, "_relValid"}, 64'(oValid), 64'd0);
    checkOutput({tag, "_relReady"}, 64'(oReady), 64'd1);
    checkOutput({tag, "_relRes"}, {oHi, oLo}, expRes);
  endtask

  initial begin
    int acceptCycles[$];
    int doneCount;

    iRst   = 1'b1;
    iValid = 1'b0;
    iReady = 1'b0;
    iA     = '0;
    iB     = '0;
    iFunc3 = '0;
    iFunc7 = 7'b0000001;
    repeat (2) @(posedge iClk);
    #1;
    checkOutput("rst_ready", 64'(oReady), 64'd1);
    checkOutput("rst_valid", 64'(oValid), 64'd0);
    checkOutput("rst_res", {oHi, oLo}, 64'd0);
    checkOutput("rst_ill", 64'(oIllegal), 64'd0);
    iRst = 1'b0;
    @(posedge iClk);
    #1;

    // Normal-path vectors (34 edges to oValid).
    applyStimulus("mulhu_max", 3'b011, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  64'hFFFFFFFE_00000001, 1'b0, 34);
    applyStimulus("mulh_neg", 3'b001, 7'b0000001, 32'hFFFFFFFE, 32'h00000003,
                  64'hFFFFFFFF_FFFFFFFA, 1'b0, 34);
    applyStimulus("mulhsu_neg", 3'b010, 7'b0000001, 32'hFFFFFFFE, 32'h00000003,
                  64'hFFFFFFFF_FFFFFFFA, 1'b0, 34);
    applyStimulus("mul_unsigned", 3'b000, 7'b0000001, 32'hFFFFFFFD, 32'h00000005,
                  64'h00000004_FFFFFFF1, 1'b0, 34);
    applyStimulus("div_neg7by2", 3'b100, 7'b0000001, 32'hFFFFFFF9, 32'h00000002,
                  64'hFFFFFFFF_FFFFFFFD, 1'b0, 34);
    applyStimulus("remu_7by2", 3'b111, 7'b0000001, 32'h00000007, 32'h00000002,
                  64'h00000001_00000003, 1'b0, 34);
    applyStimulus("div_100byneg7", 3'b100, 7'b0000001, 32'd100, 32'hFFFFFFF9,
                  64'h00000002_FFFFFFF2, 1'b0, 34);
    applyStimulus("rem_neg100by7", 3'b110, 7'b0000001, 32'hFFFFFF9C, 32'd7,
                  64'hFFFFFFFE_FFFFFFF2, 1'b0, 34);
    applyStimulus("divu_intmin", 3'b101, 7'b0000001, 32'h80000000, 32'hFFFFFFFF,
                  64'h80000000_00000000, 1'b0, 34);

    // Fast-path vectors (2 edges to oValid).
    applyStimulus("divu_zero", 3'b101, 7'b0000001, 32'h00001234, 32'h00000000,
                  64'h00001234_FFFFFFFF, 1'b0, 2);
    applyStimulus("rem_zero", 3'b110, 7'b0000001, 32'hFFFFFFFB, 32'h00000000,
                  64'hFFFFFFFB_FFFFFFFF, 1'b0, 2);
    applyStimulus("div_ovf", 3'b100, 7'b0000001, 32'h80000000, 32'hFFFFFFFF,
                  64'h00000000_80000000, 1'b0, 2);
    applyStimulus("illegal", 3'b000, 7'b0000000, 32'h00000005, 32'h00000005,
                  64'h0, 1'b1, 2);
    applyStimulus("mul_big", 3'b000, 7'b0000001, 32'h12345678, 32'h00000009,
                  64'h00000000_A3D70A38, 1'b0, 34);

    // Reset 10 cycles into RUN, with a request presented during reset.
    iA     = 32'h12345678;
    iB     = 32'h00000009;
    iFunc3 = 3'b000;
    iFunc7 = 7'b0000001;
    iValid = 1'b1;
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    repeat (11) @(posedge iClk);
    #1;
    checkOutput("midrun_busy", 64'(oReady), 64'd0);
    iRst   = 1'b1;
    iValid = 1'b1;
    @(posedge iClk);
    #1;
    checkOutput("midrst_ready", 64'(oReady), 64'd1);
    checkOutput("midrst_valid", 64'(oValid), 64'd0);
    checkOutput("midrst_res", {oHi, oLo}, 64'd0);
    checkOutput("midrst_ill", 64'(oIllegal), 64'd0);
    iRst   = 1'b0;
    iValid = 1'b0;
    @(posedge iClk);
    #1;
    checkOutput("midrst_noAccept", 64'(oReady), 64'd1);
    applyStimulus("mul_6x7", 3'b000, 7'b0000001, 32'd6, 32'd7, 64'd42, 1'b0, 34);

    // Back-to-back with both valid and ready held high.
    iA        = 32'h00010000;
    iB        = 32'h00010001;
    iFunc3    = 3'b000;
    iFunc7    = 7'b0000001;
    iValid    = 1'b1;
    iReady    = 1'b1;
    doneCount = 0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(negedge iClk);
      if (oReady && iValid) acceptCycles.push_back(cyc);
      if (oValid) begin
        doneCount++;
        checkOutput("b2b_res", {oHi, oLo}, 64'h00000001_00010000);
        checkOutput("b2b_notReady", 64'(oReady), 64'd0);
      end
    end
    iValid = 1'b0;
    checkOutput("b2b_accepts", 64'(acceptCycles.size()), 64'd5);
    checkOutput("b2b_dones", 64'(doneCount), 64'd4);
    for (int i = 1; i < acceptCycles.size(); i++) begin
      checkOutput("b2b_gap", 64'(acceptCycles[i] - acceptCycles[i-1]), 64'd36);
    end
    repeat (40) @(posedge iClk);
    #1;
    iReady = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
